// File: rtl/tlcd_pkg.sv
// Shared definitions for the Text LCD bus receiver: opcode masks, DDRAM bounds,
// character codes, FSM state type and the address-counter step rule.
// Pure definitions; no latency or backpressure of its own.
package tlcd_pkg;

    // Instruction masks; the highest set bit of the byte selects the instruction
    localparam logic [7:0] OP_CLR    = 8'h01;
    localparam logic [7:0] OP_HOME   = 8'h02;
    localparam logic [7:0] OP_ENTRY  = 8'h04;
    localparam logic [7:0] OP_DISP   = 8'h08;
    localparam logic [7:0] OP_SHIFT  = 8'h10;
    localparam logic [7:0] OP_FSET   = 8'h20;
    localparam logic [7:0] OP_SET_CG = 8'h40;
    localparam logic [7:0] OP_SET_DD = 8'h80;

    // DDRAM address map: line 0 is 0x00..0x27, line 1 is 0x40..0x67
    localparam logic [6:0] DD_L0_END = 7'h27;
    localparam logic [6:0] DD_L1_BEG = 7'h40;
    localparam logic [6:0] DD_L1_END = 7'h67;

    localparam int DD_CELLS = 80;
    localparam int LINE_LEN = 40;
    localparam int CG_CELLS = 64;

    localparam logic [7:0] BLANK_CHAR = 8'h20;

    // Custom glyph codes the font loader places in CGRAM
    localparam logic [7:0] GLYPH_0 = 8'h00;
    localparam logic [7:0] GLYPH_3 = 8'h03;
    localparam logic [7:0] GLYPH_4 = 8'h04;

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    // Next address counter value for a +1/-1 move in the current address space
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic cg, input logic up);
        logic [6:0] nxt;
        if (cg)
            nxt = {1'b0, (up ? ac[5:0] + 6'd1 : ac[5:0] - 6'd1)};
        else if (up)
            nxt = (ac == DD_L0_END) ? DD_L1_BEG : (ac == DD_L1_END) ? 7'h00 : ac + 7'd1;
        else
            nxt = (ac == DD_L1_BEG) ? DD_L0_END : (ac == 7'h00) ? DD_L1_END : ac - 7'd1;
        return nxt;
    endfunction

    // True when a 7-bit DDRAM address points at a real cell
    function automatic logic dd_addr_ok(input logic [6:0] a);
        return (a <= DD_L0_END) || ((a >= DD_L1_BEG) && (a <= DD_L1_END));
    endfunction

endpackage

// File: rtl/tlcd_strobe_capture.sv
// Holds RS/RW/DATA while E is high and flags the E falling edge.
// Latency: strobe is registered one cycle after the falling edge is sampled.
// No backpressure: every falling edge yields exactly one strobe.
module tlcd_strobe_capture
    import tlcd_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_e,
    input  logic       i_rs,
    input  logic       i_rw,
    input  logic [7:0] i_data,
    output logic       o_strb,
    output logic       o_rs,
    output logic       o_rw,
    output logic [7:0] o_data
);

    logic       r_e_q;
    logic       r_strb;
    logic       r_rs;
    logic       r_rw;
    logic [7:0] r_data;

    // Track E, latch bus fields while E is high, register the falling-edge strobe
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_e_q  <= 1'b0;
            r_strb <= 1'b0;
            r_rs   <= 1'b0;
            r_rw   <= 1'b0;
            r_data <= 8'h00;
        end else begin
            r_e_q  <= i_e;
            r_strb <= r_e_q & ~i_e;
            if (i_e) begin
                r_rs   <= i_rs;
                r_rw   <= i_rw;
                r_data <= i_data;
            end
        end
    end

    assign o_strb = r_strb;
    assign o_rs   = r_rs;
    assign o_rw   = r_rw;
    assign o_data = r_data;

endmodule

// File: rtl/tlcd_receiver.sv
// Text LCD bus receiver: decodes E strobes into a shadow DDRAM/CGRAM, address counter and flags.
// Latency: state and pulse update one cycle after the strobe; read port is one cycle.
// Strobes arriving during a clear sweep are dropped and flagged in the sticky overrun error.
module tlcd_receiver
    import tlcd_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tlcd_e,
    input  logic       i_tlcd_rs,
    input  logic       i_tlcd_rw,
    input  logic [7:0] i_tlcd_data,
    input  logic       i_rd_row,
    input  logic [5:0] i_rd_col,
    output logic [7:0] o_rd_char,
    output logic       o_busy,
    output logic [6:0] o_ac,
    output logic       o_ac_cg,
    output logic       o_disp_on,
    output logic       o_cursor_on,
    output logic       o_blink_on,
    output logic       o_inc,
    output logic       o_cmd_pulse,
    output logic       o_data_pulse,
    output logic       o_err_rw,
    output logic       o_err_addr,
    output logic       o_err_ovr
);

    logic       w_strb;
    logic       w_rs;
    logic       w_rw;
    logic [7:0] w_data;

    tlcd_strobe_capture u_cap (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_e    (i_tlcd_e),
        .i_rs   (i_tlcd_rs),
        .i_rw   (i_tlcd_rw),
        .i_data (i_tlcd_data),
        .o_strb (w_strb),
        .o_rs   (w_rs),
        .o_rw   (w_rw),
        .o_data (w_data)
    );

    state_t     r_state;
    state_t     w_state_nxt;
    logic [6:0] r_clr_idx;
    logic [6:0] r_ac;
    logic       r_ac_cg;
    logic       r_inc;
    logic       r_disp_on;
    logic       r_cursor_on;
    logic       r_blink_on;
    logic       r_cmd_pulse;
    logic       r_data_pulse;
    logic       r_err_rw;
    logic       r_err_addr;
    logic       r_err_ovr;
    logic [7:0] r_rd_char;
    logic [7:0] r_ddram [DD_CELLS];
    logic [4:0] r_cgram [CG_CELLS];

    logic [6:0] w_ac_nxt;
    logic       w_ac_cg_nxt;
    logic       w_inc_nxt;
    logic       w_disp_nxt;
    logic       w_cursor_nxt;
    logic       w_blink_nxt;
    logic       w_addr_bad;
    logic       w_clr_start;

    // Only writes outside a sweep are acted on; reads (RW=1) are never supported
    logic w_busy;
    logic w_accept;
    logic w_cmd;
    logic w_wr;
    assign w_busy   = (r_state == ST_CLEAR);
    assign w_accept = w_strb & ~w_rw & ~w_busy;
    assign w_cmd    = w_accept & ~w_rs;
    assign w_wr     = w_accept &  w_rs;

    // Linear cell index for the AC (write side) and for the read port
    logic [6:0] w_dd_wr_idx;
    logic [6:0] w_rd_idx;
    assign w_dd_wr_idx = r_ac[6] ? 7'd40 + {1'b0, r_ac[5:0]} : {1'b0, r_ac[5:0]};
    assign w_rd_idx    = i_rd_row ? 7'd40 + {1'b0, i_rd_col} : {1'b0, i_rd_col};

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Instruction decode, AC movement and sweep sequencing
    always_comb begin
        w_state_nxt  = r_state;
        w_ac_nxt     = r_ac;
        w_ac_cg_nxt  = r_ac_cg;
        w_inc_nxt    = r_inc;
        w_disp_nxt   = r_disp_on;
        w_cursor_nxt = r_cursor_on;
        w_blink_nxt  = r_blink_on;
        w_addr_bad   = 1'b0;
        w_clr_start  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_cmd) begin
                    if (|(w_data & OP_SET_DD)) begin
                        if (dd_addr_ok(w_data[6:0])) begin
                            w_ac_nxt    = w_data[6:0];
                            w_ac_cg_nxt = 1'b0;
                        end else begin
                            w_addr_bad = 1'b1;
                        end
                    end else if (|(w_data & OP_SET_CG)) begin
                        w_ac_nxt    = {1'b0, w_data[5:0]};
                        w_ac_cg_nxt = 1'b1;
                    end else if (|(w_data & OP_FSET)) begin
                        // bus width / line count are fixed here
                    end else if (|(w_data & OP_SHIFT)) begin
                        // display shift is not modelled; only cursor moves act
                        if (!w_data[3]) w_ac_nxt = ac_step(r_ac, r_ac_cg, w_data[2]);
                    end else if (|(w_data & OP_DISP)) begin
                        w_disp_nxt   = w_data[2];
                        w_cursor_nxt = w_data[1];
                        w_blink_nxt  = w_data[0];
                    end else if (|(w_data & OP_ENTRY)) begin
                        // the entry shift bit has no visible effect, so it is not kept
                        w_inc_nxt = w_data[1];
                    end else if (|(w_data & OP_HOME)) begin
                        w_ac_nxt    = 7'h00;
                        w_ac_cg_nxt = 1'b0;
                    end else if (|(w_data & OP_CLR)) begin
                        w_ac_nxt    = 7'h00;
                        w_ac_cg_nxt = 1'b0;
                        w_inc_nxt   = 1'b1;
                        w_clr_start = 1'b1;
                        w_state_nxt = ST_CLEAR;
                    end
                end else if (w_wr) begin
                    w_ac_nxt = ac_step(r_ac, r_ac_cg, r_inc);
                end
            end
            ST_CLEAR: begin
                if (r_clr_idx == 7'(DD_CELLS - 1)) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Control registers, pulses and sticky error flags
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ac         <= 7'h00;
            r_ac_cg      <= 1'b0;
            r_inc        <= 1'b1;
            r_disp_on    <= 1'b0;
            r_cursor_on  <= 1'b0;
            r_blink_on   <= 1'b0;
            r_cmd_pulse  <= 1'b0;
            r_data_pulse <= 1'b0;
            r_err_rw     <= 1'b0;
            r_err_addr   <= 1'b0;
            r_err_ovr    <= 1'b0;
        end else begin
            r_ac         <= w_ac_nxt;
            r_ac_cg      <= w_ac_cg_nxt;
            r_inc        <= w_inc_nxt;
            r_disp_on    <= w_disp_nxt;
            r_cursor_on  <= w_cursor_nxt;
            r_blink_on   <= w_blink_nxt;
            r_cmd_pulse  <= w_cmd;
            r_data_pulse <= w_wr;
            r_err_rw     <= r_err_rw   | (w_strb & w_rw);
            r_err_addr   <= r_err_addr | w_addr_bad;
            r_err_ovr    <= r_err_ovr  | (w_strb & ~w_rw & w_busy);
        end
    end

    // Sweep cell pointer: restarts on each clear, advances once per busy cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)            r_clr_idx <= 7'd0;
        else if (w_clr_start) r_clr_idx <= 7'd0;
        else if (w_busy)      r_clr_idx <= r_clr_idx + 7'd1;
    end

    // Shadow memories and registered read port (read returns pre-write contents)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DD_CELLS; i++) r_ddram[i] <= BLANK_CHAR;
            for (int i = 0; i < CG_CELLS; i++) r_cgram[i] <= 5'd0;
            r_rd_char <= BLANK_CHAR;
        end else begin
            if (w_busy)                r_ddram[r_clr_idx]   <= BLANK_CHAR;
            else if (w_wr && !r_ac_cg) r_ddram[w_dd_wr_idx] <= w_data;
            if (w_wr && r_ac_cg)       r_cgram[r_ac[5:0]]   <= w_data[4:0];
            r_rd_char <= (i_rd_col < 6'(LINE_LEN)) ? r_ddram[w_rd_idx] : BLANK_CHAR;
        end
    end

    assign o_rd_char    = r_rd_char;
    assign o_busy       = w_busy;
    assign o_ac         = r_ac;
    assign o_ac_cg      = r_ac_cg;
    assign o_disp_on    = r_disp_on;
    assign o_cursor_on  = r_cursor_on;
    assign o_blink_on   = r_blink_on;
    assign o_inc        = r_inc;
    assign o_cmd_pulse  = r_cmd_pulse;
    assign o_data_pulse = r_data_pulse;
    assign o_err_rw     = r_err_rw;
    assign o_err_addr   = r_err_addr;
    assign o_err_ovr    = r_err_ovr;

endmodule

// File: tb/tb_tlcd_receiver.sv
// Bench for tlcd_receiver: directed bus sequences plus a random instruction/data mix,
// compared against a line/column display model kept here.
// Bus driven one transfer at a time; sweeps are awaited with a cycle bound.
module tb_tlcd_receiver;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_tlcd_e = 1'b0;
    logic       i_tlcd_rs = 1'b0;
    logic       i_tlcd_rw = 1'b0;
    logic [7:0] i_tlcd_data = 8'h00;
    logic       i_rd_row = 1'b0;
    logic [5:0] i_rd_col = 6'd0;
    logic [7:0] o_rd_char;
    logic       o_busy;
    logic [6:0] o_ac;
    logic       o_ac_cg;
    logic       o_disp_on;
    logic       o_cursor_on;
    logic       o_blink_on;
    logic       o_inc;
    logic       o_cmd_pulse;
    logic       o_data_pulse;
    logic       o_err_rw;
    logic       o_err_addr;
    logic       o_err_ovr;

    tlcd_receiver dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_tlcd_e     (i_tlcd_e),
        .i_tlcd_rs    (i_tlcd_rs),
        .i_tlcd_rw    (i_tlcd_rw),
        .i_tlcd_data  (i_tlcd_data),
        .i_rd_row     (i_rd_row),
        .i_rd_col     (i_rd_col),
        .o_rd_char    (o_rd_char),
        .o_busy       (o_busy),
        .o_ac         (o_ac),
        .o_ac_cg      (o_ac_cg),
        .o_disp_on    (o_disp_on),
        .o_cursor_on  (o_cursor_on),
        .o_blink_on   (o_blink_on),
        .o_inc        (o_inc),
        .o_cmd_pulse  (o_cmd_pulse),
        .o_data_pulse (o_data_pulse),
        .o_err_rw     (o_err_rw),
        .o_err_addr   (o_err_addr),
        .o_err_ovr    (o_err_ovr)
    );

    always #5 i_clk = ~i_clk;

    int n_pass = 0;
    int n_total = 0;
    int n_cp = 0;
    int n_dp = 0;
    int n_busy = 0;

    // Pulse and busy-cycle counters, sampled mid-cycle
    always @(negedge i_clk) begin
        if (o_cmd_pulse)  n_cp++;
        if (o_data_pulse) n_dp++;
        if (o_busy)       n_busy++;
    end

    // Display model: cursor kept as (row, col) on an 80-cell ring, CGRAM address mod 64
    logic [7:0] m_dd [80];
    logic [4:0] m_cg [64];
    bit m_cgmode, m_inc, m_disp, m_cur, m_blk, m_err_rw, m_err_addr, m_err_ovr;
    int m_row, m_col, m_cga;

    task automatic m_reset();
        for (int i = 0; i < 80; i++) m_dd[i] = 8'h20;
        for (int i = 0; i < 64; i++) m_cg[i] = 5'd0;
        m_cgmode = 0; m_inc = 1; m_disp = 0; m_cur = 0; m_blk = 0;
        m_err_rw = 0; m_err_addr = 0; m_err_ovr = 0;
        m_row = 0; m_col = 0; m_cga = 0;
    endtask

    task automatic m_step(input bit up);
        int p;
        if (m_cgmode) begin
            m_cga = (m_cga + (up ? 1 : 63)) % 64;
        end else begin
            p = (m_row * 40 + m_col + (up ? 1 : 79)) % 80;
            m_row = p / 40;
            m_col = p % 40;
        end
    endtask

    function automatic logic [31:0] m_ac();
        return m_cgmode ? 32'(m_cga) : 32'(m_row * 64 + m_col);
    endfunction

    task automatic m_apply(input bit rs, input bit rw, input logic [7:0] d);
        int hb;
        int a;
        if (rw) begin
            m_err_rw = 1;
        end else if (rs) begin
            if (m_cgmode) m_cg[m_cga] = d[4:0];
            else          m_dd[m_row * 40 + m_col] = d;
            m_step(m_inc);
        end else begin
            hb = -1;
            for (int b = 0; b < 8; b++) if (d[b]) hb = b;
            case (hb)
                0: begin
                    for (int i = 0; i < 80; i++) m_dd[i] = 8'h20;
                    m_row = 0; m_col = 0; m_cgmode = 0; m_inc = 1;
                end
                1: begin m_row = 0; m_col = 0; m_cgmode = 0; end
                2: m_inc = d[1];
                3: begin m_disp = d[2]; m_cur = d[1]; m_blk = d[0]; end
                4: if (!d[3]) m_step(d[2]);
                6: begin m_cgmode = 1; m_cga = int'(d[5:0]); end
                7: begin
                    a = int'(d[6:0]);
                    if (a < 40) begin
                        m_row = 0; m_col = a; m_cgmode = 0;
                    end else if (a >= 64 && a < 104) begin
                        m_row = 1; m_col = a - 64; m_cgmode = 0;
                    end else begin
                        m_err_addr = 1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One bus transfer: E high for one cycle, then enough idle for the update to land
    task automatic strobe_raw(input bit rs, input bit rw, input logic [7:0] d);
        i_tlcd_rs = rs; i_tlcd_rw = rw; i_tlcd_data = d; i_tlcd_e = 1'b1;
        tick();
        i_tlcd_e = 1'b0;
        i_tlcd_data = ~d;
        tick(); tick(); tick();
    endtask

    task automatic send(input bit rs, input bit rw, input logic [7:0] d);
        strobe_raw(rs, rw, d);
        m_apply(rs, rw, d);
    endtask

    task automatic rd(input int row, input int col, output logic [7:0] v);
        i_rd_row = 1'(row);
        i_rd_col = 6'(col);
        tick();
        v = o_rd_char;
    endtask

    task automatic chk_dd_all(input string tag);
        logic [7:0] v;
        for (int i = 0; i < 80; i++) begin
            rd(i / 40, i % 40, v);
            chk(tag, 32'(v), 32'(m_dd[i]));
        end
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_ac"},   32'(o_ac),        m_ac());
        chk({tag, "_cg"},   32'(o_ac_cg),     32'(m_cgmode));
        chk({tag, "_inc"},  32'(o_inc),       32'(m_inc));
        chk({tag, "_disp"}, {29'd0, o_disp_on, o_cursor_on, o_blink_on}, {29'd0, m_disp, m_cur, m_blk});
        chk({tag, "_err"},  {29'd0, o_err_rw, o_err_addr, o_err_ovr}, {29'd0, m_err_rw, m_err_addr, m_err_ovr});
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] d;
        int base_p, base_b, guard, r;
        bit rs;

        // Power-up reset
        m_reset();
        tick(); tick();
        i_rst = 1'b0;
        tick();
        chk_flags("rst");
        chk("rst_busy", 32'(o_busy), 32'd0);
        rd(0, 0, v);
        chk("rst_rd00", 32'(v), 32'h20);

        // Init sequence and "HI"
        send(0, 0, 8'h38); send(0, 0, 8'h0C); send(0, 0, 8'h06); send(0, 0, 8'h80);
        base_p = n_dp;
        send(1, 0, 8'h48); send(1, 0, 8'h49);
        chk("hi_dpulses", 32'(n_dp - base_p), 32'd2);
        chk("hi_disp", 32'(o_disp_on), 32'd1);
        chk("hi_cursor", 32'(o_cursor_on), 32'd0);
        chk("hi_ac", 32'(o_ac), 32'h02);
        rd(0, 0, v); chk("hi_c00", 32'(v), 32'h48);
        rd(0, 1, v); chk("hi_c01", 32'(v), 32'h49);

        // Line wrap forward, then backward wrap from cell 0
        send(0, 0, 8'hA7); send(1, 0, 8'h41); send(1, 0, 8'h42);
        rd(0, 39, v); chk("wrap_c039", 32'(v), 32'h41);
        rd(1, 0, v);  chk("wrap_c100", 32'(v), 32'h42);
        chk("wrap_ac", 32'(o_ac), 32'h41);
        rd(0, 45, v); chk("rd_col_oob", 32'(v), 32'h20);
        send(0, 0, 8'h04); send(0, 0, 8'h80); send(1, 0, 8'h5A);
        rd(0, 0, v); chk("dec_c00", 32'(v), 32'h5A);
        chk("dec_ac", 32'(o_ac), 32'h67);

        // CGRAM fill of glyph 4
        send(0, 0, 8'h06); send(0, 0, 8'h60);
        for (int i = 0; i < 8; i++) send(1, 0, 8'h1F);
        for (int i = 0; i < 8; i++) chk("cg_row", 32'(dut.r_cgram[32 + i]), 32'h1F);
        chk("cg_ac", 32'(o_ac), 32'h28);
        chk("cg_accg", 32'(o_ac_cg), 32'd1);
        chk_dd_all("cg_dd_keep");

        // Bad DDRAM address and unsupported read
        send(0, 0, 8'hB0);
        chk("eaddr_flag", 32'(o_err_addr), 32'd1);
        chk("eaddr_ac", 32'(o_ac), 32'h28);
        base_p = n_cp + n_dp;
        send(0, 1, 8'h01);
        chk("erw_flag", 32'(o_err_rw), 32'd1);
        chk("erw_nopulse", 32'(n_cp + n_dp - base_p), 32'd0);
        chk("erw_busy", 32'(o_busy), 32'd0);
        chk_flags("erw");

        // Fill some cells, clear, and strobe during the sweep
        send(0, 0, 8'hC3);
        for (int i = 0; i < 6; i++) send(1, 0, 8'(8'h61 + i));
        base_b = n_busy;
        send(0, 0, 8'h01);
        repeat (9) tick();
        strobe_raw(1, 0, 8'h7A);
        m_err_ovr = 1;
        guard = 0;
        while (o_busy && guard < 300) begin tick(); guard++; end
        chk("clr_done", 32'(o_busy), 32'd0);
        tick();
        chk("clr_busy_len", 32'(n_busy - base_b), 32'd80);
        chk("clr_ovr", 32'(o_err_ovr), 32'd1);
        chk("clr_ac", 32'(o_ac), 32'h00);
        chk_dd_all("clr_cell");

        // Random instruction/data mix
        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 9);
            rs = 0;
            case (r)
                0, 1, 2, 3: begin rs = 1; d = 8'($urandom_range(8'h21, 8'h7E)); end
                4: d = 8'h80 | 8'($urandom_range(0, 127));
                5: d = 8'h40 | 8'($urandom_range(0, 63));
                6: d = 8'h04 | 8'($urandom_range(0, 3));
                7: d = 8'h10 | 8'($urandom_range(0, 15));
                8: d = 8'h08 | 8'($urandom_range(0, 7));
                default: d = 8'h02 | 8'($urandom_range(0, 1));
            endcase
            send(rs, 0, d);
            chk("rnd_ac", 32'(o_ac), m_ac());
            chk("rnd_accg", 32'(o_ac_cg), 32'(m_cgmode));
        end
        chk_flags("rnd_end");
        chk_dd_all("rnd_cell");
        for (int i = 0; i < 64; i++) chk("rnd_cg", 32'(dut.r_cgram[i]), 32'(m_cg[i]));

        // Reset asserted mid-sweep applies without a clock edge
        send(0, 0, 8'h0F);
        send(0, 0, 8'h01);
        repeat (5) tick();
        i_rst = 1'b1;
        #2;
        m_reset();
        chk_flags("mrst");
        chk("mrst_busy", 32'(o_busy), 32'd0);
        i_rst = 1'b0;
        tick(); tick();
        chk("mrst_busy2", 32'(o_busy), 32'd0);
        rd(0, 0, v);
        chk("mrst_rd00", 32'(v), 32'h20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
